serial_frame_tx: RTL and testbench

- Serial frame transmitter that is the driving end of the single-bit `in` stream consumed by the team's Moore sequence FSMs.
- Accepts a parallel word through a valid/ready handshake and serialises it on one line, one frame per word.
- The line idles low. Frame order: start bit (1), WIDTH data bits MSB-first, optional even-parity bit, stop bit (0).
- Used as synthesizable stimulus source and as the TX half of bit-stream links between practice blocks.

---
 rtl/serial_frame_tx.sv | 138 +++++++++++++
 tb/tb_serial_frame_tx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_tx.sv
// serial_frame_tx
//   Serialises one WIDTH-bit word per frame onto a single line that idles low.
//   Frame: start(1), WIDTH data bits MSB-first, optional even parity, stop(0).
//   Ports:
//     clk         rising-edge clock
//     rst         asynchronous reset, active low
//     in_valid    source presents a word on in_data
//     in_data     word to send, captured on the accept edge only
//     in_ready    block can take a word this cycle (state decode only)
//     out         registered serial line
//     busy        registered, high while a frame is on the line
//     frame_done  high during the final clock of the stop bit
module serial_frame_tx #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1,
  parameter int PARITY_EN  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out,
  output logic             busy,
  output logic             frame_done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             par_q, par_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [7:0]       cyc_q, cyc_d;
  logic             out_q, out_d;
  logic             busy_q, busy_d;

  logic cyc_last, bit_last, accept;

  assign cyc_last = (cyc_q == 8'(BIT_CYCLES - 1));
  assign bit_last = (bit_q == BW'(WIDTH - 1));

  // Ready is also raised in the last stop clock so a waiting word can start
  // the next frame with no idle gap.
  assign in_ready   = (state_q == IDLE) || ((state_q == STOP) && cyc_last);
  assign frame_done = (state_q == STOP) && cyc_last;
  assign accept     = in_valid && in_ready;

  assign out  = out_q;
  assign busy = busy_q;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    bit_d   = bit_q;
    cyc_d   = cyc_q;

    if (state_q == IDLE) begin
      if (accept) begin
        state_d = START;
        shreg_d = in_data;
        par_d   = ^in_data;
        bit_d   = '0;
        cyc_d   = '0;
      end
    end else if (!cyc_last) begin
      cyc_d = cyc_q + 8'd1;
    end else begin
      cyc_d = '0;
      unique case (state_q)
        START: begin
          state_d = DATA;
          bit_d   = '0;
        end
        DATA: begin
          // The line always shows shreg MSB, so shift at the end of each bit.
          shreg_d = shreg_q << 1;
          if (bit_last) state_d = (PARITY_EN != 0) ? PARITY : STOP;
          else          bit_d   = bit_q + BW'(1);
        end
        PARITY: state_d = STOP;
        STOP: begin
          if (accept) begin
            state_d = START;
            shreg_d = in_data;
            par_d   = ^in_data;
            bit_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // out/busy are registered, so decode them from the state being entered.
  always_comb begin
    out_d  = 1'b0;
    busy_d = (state_d != IDLE);
    unique case (state_d)
      START:   out_d = 1'b1;
      DATA:    out_d = shreg_d[WIDTH-1];
      PARITY:  out_d = par_d;
      default: out_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      par_q   <= 1'b0;
      bit_q   <= '0;
      cyc_q   <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      bit_q   <= bit_d;
      cyc_q   <= cyc_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
module tb_serial_frame_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  // default instance: WIDTH=8, BIT_CYCLES=1, PARITY_EN=1
  logic       in_valid = 1'b0;
  logic [7:0] in_data  = '0;
  logic       in_ready, out, busy, frame_done;
  // stretched instance: WIDTH=4, BIT_CYCLES=3, PARITY_EN=0
  logic       in_valid3 = 1'b0;
  logic [3:0] in_data3  = '0;
  logic       in_ready3, out3, busy3, frame_done3;

  int checks   = 0;
  int failures = 0;

  serial_frame_tx #(.WIDTH(8), .BIT_CYCLES(1), .PARITY_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out(out), .busy(busy), .frame_done(frame_done)
  );

  serial_frame_tx #(.WIDTH(4), .BIT_CYCLES(3), .PARITY_EN(0)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_data(in_data3),
    .in_ready(in_ready3), .out(out3), .busy(busy3), .frame_done(frame_done3)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    in_valid3 = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    checks++;
    if (out !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset: out=%b busy=%b done=%b rdy=%b want 0 0 0 1", out, busy, frame_done, in_ready);
    end
    checks++;
    if (out3 !== 1'b0 || busy3 !== 1'b0 || frame_done3 !== 1'b0 || in_ready3 !== 1'b1) begin
      failures++;
      $display("FAIL reset3: out=%b busy=%b done=%b rdy=%b want 0 0 0 1", out3, busy3, frame_done3, in_ready3);
    end
    do_reset();
  endtask

  task automatic test_idle_hold();
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (out !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || frame_done !== 1'b0) begin
        failures++;
        $display("FAIL idle[%0d]: out=%b busy=%b rdy=%b done=%b want 0 0 1 0", i, out, busy, in_ready, frame_done);
      end
      tick();
    end
  endtask

  // Sends one word on the default instance and checks the 11-clock frame.
  task automatic run_frame(input string name, input logic [7:0] w, input logic [10:0] exp);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (out !== exp[10-i] || busy !== 1'b1 || frame_done !== (i == 10) || in_ready !== (i == 10)) begin
        failures++;
        $display("FAIL %s clk%0d: out=%b busy=%b done=%b rdy=%b want %b 1 %b %b",
                 name, i+1, out, busy, frame_done, in_ready, exp[10-i], (i == 10), (i == 10));
      end
      tick();
    end
    checks++;
    if (busy !== 1'b0 || out !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_end: busy=%b out=%b rdy=%b want 0 0 1", name, busy, out, in_ready);
    end
  endtask

  task automatic test_single_frame();
    run_frame("a5", 8'hA5, 11'b11010010100);
  endtask

  task automatic test_back_to_back();
    logic [21:0] exp;
    int dones;
    exp   = {11'b10000000110, 11'b11000000010};
    dones = 0;
    in_valid = 1'b1;
    in_data  = 8'h01;
    tick();
    in_data  = 8'h80;
    for (int i = 0; i < 22; i++) begin
      if (i == 11) in_valid = 1'b0;
      if (frame_done === 1'b1) dones++;
      checks++;
      if (out !== exp[21-i] || busy !== 1'b1 || frame_done !== (i == 10 || i == 21)) begin
        failures++;
        $display("FAIL b2b clk%0d: out=%b busy=%b done=%b want %b 1 %b",
                 i+1, out, busy, frame_done, exp[21-i], (i == 10 || i == 21));
      end
      tick();
    end
    checks++;
    if (dones != 2 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end: dones=%0d busy=%b want 2 0", dones, busy);
    end
  endtask

  task automatic test_stretched();
    logic [17:0] exp;
    exp = 18'b111111000111111000;
    in_valid3 = 1'b1;
    in_data3  = 4'b1011;
    tick();
    in_valid3 = 1'b0;
    for (int i = 0; i < 18; i++) begin
      checks++;
      if (out3 !== exp[17-i] || busy3 !== 1'b1 || frame_done3 !== (i == 17) || in_ready3 !== (i == 17)) begin
        failures++;
        $display("FAIL stretch clk%0d: out=%b busy=%b done=%b rdy=%b want %b 1 %b %b",
                 i+1, out3, busy3, frame_done3, in_ready3, exp[17-i], (i == 17), (i == 17));
      end
      tick();
    end
    checks++;
    if (busy3 !== 1'b0 || out3 !== 1'b0) begin
      failures++;
      $display("FAIL stretch_end: busy=%b out=%b want 0 0", busy3, out3);
    end
  endtask

  task automatic test_handshake_ignore();
    logic [10:0] exp;
    exp = 11'b11111111100;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (i == 3) begin in_data = 8'h00; in_valid = 1'b1; end
      if (i == 6) in_valid = 1'b0;
      checks++;
      if (out !== exp[10-i] || frame_done !== (i == 10)) begin
        failures++;
        $display("FAIL ignore clk%0d: out=%b done=%b want %b %b", i+1, out, frame_done, exp[10-i], (i == 10));
      end
      tick();
    end
    tick();
    checks++;
    if (busy !== 1'b0 || out !== 1'b0) begin
      failures++;
      $display("FAIL ignore_capture: busy=%b out=%b want 0 0", busy, out);
    end
  endtask

  task automatic test_mid_reset();
    in_valid = 1'b1;
    in_data  = 8'hC3;
    tick();
    in_valid = 1'b0;
    tick(); // first data bit
    tick(); // second data bit, line high
    checks++;
    if (out !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre: out=%b busy=%b want 1 1", out, busy);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (out !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL midrst_async: out=%b busy=%b done=%b want 0 0 0", out, busy, frame_done);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (frame_done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL midrst_hold%0d: done=%b busy=%b want 0 0", i, frame_done, busy);
      end
    end
    // release with a word already presented: accept on the first live edge
    #2;
    rst = 1'b1;
    run_frame("3c", 8'h3C, 11'b10011110000);
  endtask

  initial begin
    test_reset();
    test_idle_hold();
    test_single_frame();
    tick();
    test_back_to_back();
    tick();
    test_stretched();
    tick();
    test_handshake_ignore();
    tick();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded");
    $fatal(1);
  end

endmodule
